ac_zone_control: RTL and testbench
==================================

# ac_zone_control

Multi-zone successor to the single-zone AC controller. It runs ZONES independent climate channels, one per room, each with its own mode cycle, saturating setpoint and hysteretic heat/cool decision. Fan speed is rate-limited by a per-zone ramp. It sits between the per-room button/sensor front-end and the fan/heater drivers of the home-automation top level.

## Interface
- ZONES, 4, number of independent channels (1..8)
- TEMP_W, 7, width of temperature and setpoint values (unsigned °C)
- SET_MIN, 16, lowest setpoint
- SET_MAX, 30, highest setpoint
- SET_RESET, 22, setpoint after reset
- HYST, 1, hysteresis band in °C (≥1)
- RAMP_CYC, 4, clocks between successive one-step fan_speed changes (≥1)

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- button_ac  in  ZONES  per-zone mode button, level input
- button_up  in  ZONES  per-zone setpoint +1 button
- button_down  in  ZONES  per-zone setpoint −1 button
- temperature  in  ZONES*TEMP_W  measured temperature; zone z at [z*TEMP_W +: TEMP_W]
- fan_speed  out  ZONES*3  fan speed 0..7 per zone
- fan_heat  out  ZONES*8  heater drive 0..255 per zone
- mode_select  out  ZONES*2  current mode per zone: 00 OFF, 01 AUTO, 10 FAST_COOL, 11 ECO
- temperature_registered  out  ZONES*TEMP_W  current setpoint per zone

## Operation
- Buttons are edge-detected per zone. A press is the button high this cycle while the registered previous value is low. The previous-value registers reset to 1, so a button held through reset is not a press.
- Mode FSM per zone, advanced on a button_ac press: OFF→AUTO→FAST_COOL→ECO→OFF.
- Setpoint, in any mode except OFF:
  - up press: +1, saturates at SET_MAX
  - down press: −1, saturates at SET_MIN
  - up and down pressed in the same cycle: no change
  - presses in OFF are ignored
- diff = temperature − setpoint, signed, TEMP_W+1 bits; |diff| is clamped for output scaling.
- Hysteresis flags per zone, cool_on and heat_on:
  - cool_on sets when diff > HYST and clears when diff ≤ 0.
  - heat_on sets when diff < −HYST and clears when diff ≥ 0.
  - Both flags clear in OFF and in FAST_COOL.
- Targets by mode:
  - OFF: speed 0, heat 0.
  - AUTO:
    - cool_on: speed min(|diff|,7), heat 0.
    - heat_on: speed min(|diff|,7), heat min(|diff|*16,255).
    - Neither flag set: speed 0, heat 0.
  - FAST_COOL: speed 7, heat 0.
  - ECO: same as AUTO, then speed capped at 3 and heat capped at 64.
- Ramp:
  - Each zone has a counter counting down RAMP_CYC−1..0.
  - When it reaches 0 and fan_speed ≠ target, fan_speed moves one step toward the target and the counter reloads.
  - While fan_speed = target, the counter holds at 0, so the next change occurs on the following edge.
  - Entering OFF or FAST_COOL bypasses the ramp: fan_speed takes its target on the next edge and the counter reloads.
- fan_heat is not ramped; it tracks its target registered.
- Zones share nothing except clk and reset.

## Timing
- Reset values: mode_select 00 in all zones; temperature_registered = SET_RESET; fan_speed 0; fan_heat 0; flags 0; ramp counters 0.
- A press sampled at edge n updates mode_select and temperature_registered at edge n, i.e. they are visible one cycle after the button rises.
- The flags, fan_heat and bypass fan_speed use that new mode one edge later (n+1).
- A temperature input change updates the flags and fan_heat on the next edge. The setpoint used is the registered one.
- Ramp: from speed 0 toward target 5 with RAMP_CYC=4, the first step comes one edge after the target appears. Later steps come every 4 edges, so speed reaches 5 after 1+4*4 = 17 edges.
- A reset asserted mid-ramp or mid-press returns every zone to its reset values on that edge. Buttons still high afterwards are not presses.
- Holding a button high yields exactly one press.

## Test plan
- Reset and hold: apply reset 2 cycles with button_ac[0]=1 held. Require all outputs at reset values and mode_select zone0 still 00 10 cycles after release.
- Mode cycle and isolation (ZONES=2): press button_ac[1] 4 times. Require zone1 mode to go 01,10,11,00, one cycle after each press, and zone0 to stay 00.
- Setpoint saturation: zone0 in AUTO, 10 up presses → temperature_registered=30. Then 20 down presses → 16. Then up+down pressed together → stays 16. Up presses in OFF → unchanged.
- AUTO cool with ramp: setpoint 22, temperature 28. Require fan_heat 0, fan_speed stepping 1,2,…,6 at the RAMP_CYC=4 cadence. Then temperature 23 keeps speed ramping down to 1 (cool_on held); temperature 22 drops the target to 0.
- Heat and ECO caps: setpoint 22, temperature 14. AUTO → fan_heat 128, speed target 7. ECO → fan_heat 64, speed ramps down to 3. FAST_COOL → speed 7 on the next edge, heat 0.
- Hysteresis: setpoint 22 in AUTO, temperature 23 → flags clear, speed 0. Then temperature 24 → cool_on sets, target 2. Then temperature 23 → target 1, not 0.

Source files
------------

// File: rtl/ac_zone_control.sv
// ============================================================================
// Module   : ac_zone_control
// Brief    : ZONES independent climate channels with mode cycle, saturating
//            setpoint, hysteretic heat/cool flags and ramp-limited fan speed.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ac_zone_control #(
    parameter int ZONES     = 4,
    parameter int TEMP_W    = 7,
    parameter int SET_MIN   = 16,
    parameter int SET_MAX   = 30,
    parameter int SET_RESET = 22,
    parameter int HYST      = 1,
    parameter int RAMP_CYC  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ZONES-1:0]          button_ac,
    input  logic [ZONES-1:0]          button_up,
    input  logic [ZONES-1:0]          button_down,
    input  logic [ZONES*TEMP_W-1:0]   temperature,
    output logic [ZONES*3-1:0]        fan_speed,
    output logic [ZONES*8-1:0]        fan_heat,
    output logic [ZONES*2-1:0]        mode_select,
    output logic [ZONES*TEMP_W-1:0]   temperature_registered
);

    localparam int DW = TEMP_W + 1;
    localparam int CW = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;

    localparam logic [CW-1:0]         c_RELOAD    = CW'(RAMP_CYC - 1);
    localparam logic [TEMP_W-1:0]     c_SET_MIN   = TEMP_W'(SET_MIN);
    localparam logic [TEMP_W-1:0]     c_SET_MAX   = TEMP_W'(SET_MAX);
    localparam logic [TEMP_W-1:0]     c_SET_RESET = TEMP_W'(SET_RESET);
    localparam logic signed [DW-1:0]  c_HYST      = DW'(HYST);
    localparam logic signed [DW-1:0]  c_ZERO      = '0;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_AUTO = 2'b01,
        MODE_FAST = 2'b10,
        MODE_ECO  = 2'b11
    } mode_t;

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        logic                  r_prev_ac, r_prev_up, r_prev_dn;
        logic                  w_press_ac, w_press_up, w_press_dn;
        mode_t                 r_mode, w_mode_next;
        logic [TEMP_W-1:0]     r_set, w_set_next;
        logic                  r_cool, r_heat, w_cool_next, w_heat_next;
        logic signed [DW-1:0]  w_diff;
        logic [DW-1:0]         w_abs;
        logic [2:0]            w_spd_raw, w_spd_tgt, r_speed, w_speed_next;
        logic [7:0]            w_heat_raw, w_heat_tgt, r_heat_drv;
        logic [CW-1:0]         r_cnt, w_cnt_next;
        logic                  w_bypass;

        assign w_press_ac = button_ac[z]   & ~r_prev_ac;
        assign w_press_up = button_up[z]   & ~r_prev_up;
        assign w_press_dn = button_down[z] & ~r_prev_dn;

        assign w_diff = $signed({1'b0, temperature[z*TEMP_W +: TEMP_W]}) - $signed({1'b0, r_set});
        assign w_abs  = w_diff[DW-1] ? (~w_diff + 1'b1) : w_diff;

        always_ff @(posedge clk) begin
            if (reset) begin
                // Previous values start high so a button held through reset is not a press
                r_prev_ac  <= 1'b1;
                r_prev_up  <= 1'b1;
                r_prev_dn  <= 1'b1;
                r_mode     <= MODE_OFF;
                r_set      <= c_SET_RESET;
                r_cool     <= 1'b0;
                r_heat     <= 1'b0;
                r_speed    <= 3'd0;
                r_heat_drv <= 8'd0;
                r_cnt      <= '0;
            end else begin
                r_prev_ac  <= button_ac[z];
                r_prev_up  <= button_up[z];
                r_prev_dn  <= button_down[z];
                r_mode     <= w_mode_next;
                r_set      <= w_set_next;
                r_cool     <= w_cool_next;
                r_heat     <= w_heat_next;
                r_speed    <= w_speed_next;
                r_heat_drv <= w_heat_tgt;
                r_cnt      <= w_cnt_next;
            end
        end

        always_comb begin
            w_mode_next = r_mode;
            if (w_press_ac) begin
                case (r_mode)
                    MODE_OFF:  w_mode_next = MODE_AUTO;
                    MODE_AUTO: w_mode_next = MODE_FAST;
                    MODE_FAST: w_mode_next = MODE_ECO;
                    default:   w_mode_next = MODE_OFF;
                endcase
            end

            w_set_next = r_set;
            if (r_mode != MODE_OFF) begin
                if (w_press_up && !w_press_dn && r_set < c_SET_MAX)
                    w_set_next = r_set + 1'b1;
                else if (w_press_dn && !w_press_up && r_set > c_SET_MIN)
                    w_set_next = r_set - 1'b1;
            end

            w_bypass    = (r_mode == MODE_OFF) || (r_mode == MODE_FAST);
            w_cool_next = r_cool;
            w_heat_next = r_heat;
            if (w_bypass) begin
                w_cool_next = 1'b0;
                w_heat_next = 1'b0;
            end else begin
                if (w_diff > c_HYST)        w_cool_next = 1'b1;
                else if (w_diff <= c_ZERO)  w_cool_next = 1'b0;
                if (w_diff < -c_HYST)       w_heat_next = 1'b1;
                else if (w_diff >= c_ZERO)  w_heat_next = 1'b0;
            end

            w_spd_raw  = (w_abs >= DW'(7))  ? 3'd7   : w_abs[2:0];
            w_heat_raw = (w_abs >= DW'(16)) ? 8'd255 : {w_abs[3:0], 4'b0000};

            w_spd_tgt  = 3'd0;
            w_heat_tgt = 8'd0;
            case (r_mode)
                MODE_FAST: w_spd_tgt = 3'd7;
                MODE_AUTO, MODE_ECO: begin
                    if (w_cool_next) begin
                        w_spd_tgt = w_spd_raw;
                    end else if (w_heat_next) begin
                        w_spd_tgt  = w_spd_raw;
                        w_heat_tgt = w_heat_raw;
                    end
                    if (r_mode == MODE_ECO) begin
                        if (w_spd_tgt > 3'd3)   w_spd_tgt  = 3'd3;
                        if (w_heat_tgt > 8'd64) w_heat_tgt = 8'd64;
                    end
                end
                default: ;
            endcase

            // Counter parks at zero once on target so a new target steps on the next edge
            w_speed_next = r_speed;
            w_cnt_next   = r_cnt;
            if (w_bypass) begin
                w_speed_next = w_spd_tgt;
                w_cnt_next   = c_RELOAD;
            end else if (r_cnt != '0) begin
                w_cnt_next = r_cnt - 1'b1;
            end else if (r_speed != w_spd_tgt) begin
                w_speed_next = (r_speed < w_spd_tgt) ? r_speed + 3'd1 : r_speed - 3'd1;
                w_cnt_next   = c_RELOAD;
            end
        end

        assign fan_speed[z*3 +: 3]                   = r_speed;
        assign fan_heat[z*8 +: 8]                    = r_heat_drv;
        assign mode_select[z*2 +: 2]                 = r_mode;
        assign temperature_registered[z*TEMP_W +: TEMP_W] = r_set;
    end

endmodule

`default_nettype wire

// File: tb/tb_ac_zone_control.sv
// Randomized scoreboard bench for ac_zone_control against a per-zone
// behavioural model built from the climate rules with integer arithmetic.
`default_nettype none

module tb_ac_zone_control;
    localparam int ZONES = 4, TEMP_W = 7, SET_MIN = 16, SET_MAX = 30;
    localparam int SET_RESET = 22, HYST = 1, RAMP_CYC = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic [ZONES-1:0] button_ac = '0, button_up = '0, button_down = '0;
    logic [ZONES*TEMP_W-1:0] temperature = '0;
    logic [ZONES*3-1:0] fan_speed;
    logic [ZONES*8-1:0] fan_heat;
    logic [ZONES*2-1:0] mode_select;
    logic [ZONES*TEMP_W-1:0] temperature_registered;

    ac_zone_control #(.ZONES(ZONES), .TEMP_W(TEMP_W), .SET_MIN(SET_MIN), .SET_MAX(SET_MAX),
                      .SET_RESET(SET_RESET), .HYST(HYST), .RAMP_CYC(RAMP_CYC)) dut (
        .clk(clk), .reset(reset), .button_ac(button_ac), .button_up(button_up),
        .button_down(button_down), .temperature(temperature), .fan_speed(fan_speed),
        .fan_heat(fan_heat), .mode_select(mode_select),
        .temperature_registered(temperature_registered));

    always #5 clk = ~clk;

    typedef struct {
        int spd[ZONES];
        int hd[ZONES];
        int md[ZONES];
        int st[ZONES];
    } exp_t;

    exp_t sb_q[$];
    int checks = 0, errors = 0;
    bit stim_done = 1'b0;

    // Model state: mode 0 OFF, 1 AUTO, 2 FAST_COOL, 3 ECO
    int m_mode[ZONES], m_set[ZONES], m_spd[ZONES], m_hd[ZONES], m_cnt[ZONES];
    bit m_cool[ZONES], m_heat[ZONES], m_pac[ZONES], m_pup[ZONES], m_pdn[ZONES];

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    task automatic model_step();
        exp_t e;
        for (int z = 0; z < ZONES; z++) begin
            if (reset) begin
                m_mode[z] = 0; m_set[z] = SET_RESET; m_spd[z] = 0; m_hd[z] = 0; m_cnt[z] = 0;
                m_cool[z] = 0; m_heat[z] = 0; m_pac[z] = 1; m_pup[z] = 1; m_pdn[z] = 1;
            end else begin
                int t, diff, a, tspd, theat, nmode, nset;
                bit pac, pup, pdn, active;
                t    = int'(temperature[z*TEMP_W +: TEMP_W]);
                diff = t - m_set[z];
                a    = (diff < 0) ? -diff : diff;
                pac  = button_ac[z] && !m_pac[z];
                pup  = button_up[z] && !m_pup[z];
                pdn  = button_down[z] && !m_pdn[z];
                nmode = pac ? (m_mode[z] + 1) % 4 : m_mode[z];
                nset  = m_set[z];
                if (m_mode[z] != 0 && pup && !pdn) nset = imin(m_set[z] + 1, SET_MAX);
                if (m_mode[z] != 0 && pdn && !pup) nset = imax(m_set[z] - 1, SET_MIN);
                active = (m_mode[z] == 1) || (m_mode[z] == 3);
                if (!active) begin
                    m_cool[z] = 0; m_heat[z] = 0;
                end else begin
                    if (diff > HYST) m_cool[z] = 1; else if (diff <= 0) m_cool[z] = 0;
                    if (diff < -HYST) m_heat[z] = 1; else if (diff >= 0) m_heat[z] = 0;
                end
                tspd = 0; theat = 0;
                if (m_mode[z] == 2) tspd = 7;
                if (active && (m_cool[z] || m_heat[z])) tspd = imin(a, 7);
                if (active && m_heat[z] && !m_cool[z]) theat = imin(a * 16, 255);
                if (m_mode[z] == 3) begin tspd = imin(tspd, 3); theat = imin(theat, 64); end
                if (!active) begin
                    m_spd[z] = tspd; m_cnt[z] = RAMP_CYC - 1;
                end else if (m_cnt[z] > 0) begin
                    m_cnt[z]--;
                end else if (m_spd[z] != tspd) begin
                    m_spd[z] += (tspd > m_spd[z]) ? 1 : -1;
                    m_cnt[z] = RAMP_CYC - 1;
                end
                m_hd[z] = theat;
                m_mode[z] = nmode; m_set[z] = nset;
                m_pac[z] = button_ac[z]; m_pup[z] = button_up[z]; m_pdn[z] = button_down[z];
            end
            e.spd[z] = m_spd[z]; e.hd[z] = m_hd[z]; e.md[z] = m_mode[z]; e.st[z] = m_set[z];
        end
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input int z, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s zone%0d got %0d expected %0d at %0t", name, z, act, exp_v, $time);
        end
    endtask

    // Monitor: every edge presents one output snapshot
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                for (int z = 0; z < ZONES; z++) begin
                    chk("mode_select", z, int'(mode_select[z*2 +: 2]), e.md[z]);
                    chk("setpoint", z, int'(temperature_registered[z*TEMP_W +: TEMP_W]), e.st[z]);
                    chk("fan_speed", z, int'(fan_speed[z*3 +: 3]), e.spd[z]);
                    chk("fan_heat", z, int'(fan_heat[z*8 +: 8]), e.hd[z]);
                end
            end
        end
    end

    task automatic drive_cycle();
        @(negedge clk);
        model_step();
    endtask

    initial begin
        // Reset with zone0 mode button held, then keep holding after release
        reset = 1'b1;
        button_ac[0] = 1'b1;
        for (int z = 0; z < ZONES; z++) temperature[z*TEMP_W +: TEMP_W] = TEMP_W'(22);
        repeat (2) drive_cycle();
        reset = 1'b0;
        repeat (10) drive_cycle();
        button_ac[0] = 1'b0;
        drive_cycle();

        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 1499) == 0);
            for (int z = 0; z < ZONES; z++) begin
                if ($urandom_range(0, 59) == 0) button_ac[z] = ~button_ac[z];
                if ($urandom_range(0, 5) == 0) button_up[z] = ~button_up[z];
                if ($urandom_range(0, 5) == 0) button_down[z] = ~button_down[z];
                if ($urandom_range(0, 24) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        temperature[z*TEMP_W +: TEMP_W] = TEMP_W'($urandom_range(0, 60));
                    else
                        temperature[z*TEMP_W +: TEMP_W] =
                            TEMP_W'(imax(m_set[z] + int'($urandom_range(0, 20)) - 10, 0));
                end
            end
            model_step();
        end
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
